// File: rtl/jt12_opseq_pkg.sv
// Shared definitions for the JT12 operator sequencer: slot ordering, channel
// count and the slot-number to {channel, operator} decode.
package jt12_opseq_pkg;

  localparam int NUM_CH     = 6;
  localparam int SLOT_COUNT = 24;
  localparam logic [4:0] LAST_SLOT = 5'(SLOT_COUNT - 1);

  // Operators run in the order S1, S3, S2, S4 within a frame
  typedef enum logic [1:0] {
    OP_S1 = 2'd0,
    OP_S3 = 2'd1,
    OP_S2 = 2'd2,
    OP_S4 = 2'd3
  } op_e;

  typedef struct packed {
    logic [2:0] ch;
    op_e        op;
  } slot_id_t;

  // Delayed slot ID after reset: S4 never writes history, so the first edge is a no-op
  localparam slot_id_t RESET_DLY = '{ch: 3'd5, op: OP_S4};

  // Split a 0..23 slot number into operator (slot/6) and channel (slot mod 6)
  function automatic slot_id_t slot_decode(input logic [4:0] slot);
    slot_id_t id;
    if (slot >= 5'd18) begin
      id.op = OP_S4;
      id.ch = 3'(slot - 5'd18);
    end else if (slot >= 5'd12) begin
      id.op = OP_S2;
      id.ch = 3'(slot - 5'd12);
    end else if (slot >= 5'd6) begin
      id.op = OP_S3;
      id.ch = 3'(slot - 5'd6);
    end else begin
      id.op = OP_S1;
      id.ch = 3'(slot);
    end
    return id;
  endfunction

endpackage

// File: rtl/jt12_opseq_mod.sv
// Modulation source-select decode: given which operator is running and the
// channel algorithm, choose where the x and y modulation operands come from.
module jt12_mod #(
  parameter int num_ch = 6
) (
  input  logic       s1_enters_i,
  input  logic       s2_enters_i,
  input  logic       s3_enters_i,
  input  logic       s4_enters_i,
  input  logic [2:0] alg_i,
  output logic       xuse_prevprev1_o,
  output logic       xuse_prev2_o,
  output logic       xuse_internal_o,
  output logic       yuse_prev1_o,
  output logic       yuse_internal_o
);

  logic [7:0] algHot;

  assign algHot = 8'd1 << alg_i;

  generate
    if (num_ch == 6) begin : g_six
      // Connection table of the eight FM algorithms; S1 always feeds back on itself
      always_comb begin
        xuse_prevprev1_o = s1_enters_i | (s3_enters_i & algHot[5]);
        xuse_prev2_o     = (s3_enters_i & (|algHot[2:0])) | (s4_enters_i & algHot[3]);
        xuse_internal_o  = s4_enters_i & algHot[2];
        yuse_internal_o  = s4_enters_i & (|{algHot[4:3], algHot[1:0]});
        yuse_prev1_o     = s1_enters_i
                         | (s3_enters_i & algHot[1])
                         | (s2_enters_i & (|{algHot[6:3], algHot[0]}))
                         | (s4_enters_i & (|{algHot[5], algHot[2]}));
      end
    end else begin : g_unsupported
      // Only the six-channel slot layout is defined; other sizes get no modulation
      always_comb begin
        xuse_prevprev1_o = 1'b0;
        xuse_prev2_o     = 1'b0;
        xuse_internal_o  = 1'b0;
        yuse_internal_o  = 1'b0;
        yuse_prev1_o     = 1'b0;
      end
    end
  endgenerate

endmodule

// File: rtl/jt12_opseq.sv
// JT12 operator sequencer: walks the 24 operator slots, holds per-channel
// algorithms and operator history, and presents the modulation operands for
// the slot currently running.
module jt12_opseq import jt12_opseq_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               alg_wr,
  input  logic [2:0]         alg_ch,
  input  logic [2:0]         alg_din,
  input  logic signed [13:0] op_result,
  output logic [2:0]         cur_ch,
  output logic [1:0]         cur_op,
  output logic               s1_enters,
  output logic               s2_enters,
  output logic               s3_enters,
  output logic               s4_enters,
  output logic [2:0]         alg_I,
  output logic signed [13:0] mod_x,
  output logic signed [13:0] mod_y,
  output logic               zero
);

  logic [4:0]         slot_q;
  logic [4:0]         slot_d;
  slot_id_t           curId;
  slot_id_t           dly_q;
  logic               algWrEn;
  logic [2:0]         alg_q    [NUM_CH];
  logic signed [13:0] s1_d1_q  [NUM_CH];
  logic signed [13:0] s1_d2_q  [NUM_CH];
  logic signed [13:0] s2_out_q [NUM_CH];
  logic signed [13:0] s3_out_q [NUM_CH];
  logic signed [13:0] prevprev1;
  logic signed [13:0] prev1;
  logic signed [13:0] prev2;
  logic signed [13:0] internalSrc;
  logic               xUsePrevprev1;
  logic               xUsePrev2;
  logic               xUseInternal;
  logic               yUsePrev1;
  logic               yUseInternal;

  assign curId     = slot_decode(slot_q);
  assign cur_ch    = curId.ch;
  assign cur_op    = curId.op;
  assign s1_enters = (curId.op == OP_S1);
  assign s2_enters = (curId.op == OP_S2);
  assign s3_enters = (curId.op == OP_S3);
  assign s4_enters = (curId.op == OP_S4);
  assign zero      = (slot_q == 5'd0);
  assign algWrEn   = cen & alg_wr & (alg_ch < 3'd6);
  assign alg_I     = alg_q[cur_ch];

  // Next slot number, wrapping after the last S4 slot
  always_comb begin
    slot_d = (slot_q == LAST_SLOT) ? 5'd0 : slot_q + 5'd1;
  end

  // Slot counter and one-edge-delayed slot ID that tells where op_result belongs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= 5'd0;
      dly_q  <= RESET_DLY;
    end else if (cen) begin
      slot_q <= slot_d;
      dly_q  <= curId;
    end
  end

  // Algorithm registers; writes to channels 6 and 7 fall on the floor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) alg_q[i] <= 3'd0;
    end else if (algWrEn) begin
      alg_q[alg_ch] <= alg_din;
    end
  end

  // Store the previous slot's operator output into that channel's history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        s1_d1_q[i]  <= '0;
        s1_d2_q[i]  <= '0;
        s2_out_q[i] <= '0;
        s3_out_q[i] <= '0;
      end
    end else if (cen) begin
      case (dly_q.op)
        OP_S1: begin
          s1_d2_q[dly_q.ch] <= s1_d1_q[dly_q.ch];
          s1_d1_q[dly_q.ch] <= op_result;
        end
        OP_S2:   s2_out_q[dly_q.ch] <= op_result;
        OP_S3:   s3_out_q[dly_q.ch] <= op_result;
        default: ;
      endcase
    end
  end

  jt12_mod #(
    .num_ch(NUM_CH)
  ) u_mod (
    .s1_enters_i     (s1_enters),
    .s2_enters_i     (s2_enters),
    .s3_enters_i     (s3_enters),
    .s4_enters_i     (s4_enters),
    .alg_i           (alg_I),
    .xuse_prevprev1_o(xUsePrevprev1),
    .xuse_prev2_o    (xUsePrev2),
    .xuse_internal_o (xUseInternal),
    .yuse_prev1_o    (yUsePrev1),
    .yuse_internal_o (yUseInternal)
  );

  // Pick the modulation operands from the current channel's history
  always_comb begin
    prev1       = s1_d1_q[cur_ch];
    prevprev1   = s1_enters ? s1_d2_q[cur_ch] : s1_d1_q[cur_ch];
    prev2       = s2_out_q[cur_ch];
    internalSrc = s3_out_q[cur_ch];
    mod_x       = '0;
    mod_y       = '0;
    if (xUsePrevprev1)     mod_x = prevprev1;
    else if (xUsePrev2)    mod_x = prev2;
    else if (xUseInternal) mod_x = internalSrc;
    if (yUsePrev1)         mod_y = prev1;
    else if (yUseInternal) mod_y = internalSrc;
  end

endmodule

// File: tb/tb_jt12_opseq.sv
// Scoreboard bench for jt12_opseq: a frame-level model predicts every cycle's
// outputs, a monitor compares them at the falling edge, and a few directed
// scenarios add fixed-value checks.
module tb_jt12_opseq;

  logic               clk = 1'b0;
  logic               rst;
  logic               cen;
  logic               alg_wr;
  logic [2:0]         alg_ch;
  logic [2:0]         alg_din;
  logic signed [13:0] op_result;
  logic [2:0]         cur_ch;
  logic [1:0]         cur_op;
  logic               s1_enters;
  logic               s2_enters;
  logic               s3_enters;
  logic               s4_enters;
  logic [2:0]         alg_I;
  logic signed [13:0] mod_x;
  logic signed [13:0] mod_y;
  logic               zero;

  typedef struct {
    int ch;
    int op;
    int enters;
    int alg;
    int mx;
    int my;
    int zero;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  bit   stimDone = 1'b0;

  // Reference model state: slot number, previous slot, algorithms, history
  int mSlot;
  int mPrev;
  bit mPrevValid;
  int mAlg[6];
  int mS1a[6];
  int mS1b[6];
  int mS2[6];
  int mS3[6];

  // Forced operator results, indexed by the slot whose result they are
  bit feedEn[24];
  int feedVal[24];

  jt12_opseq dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .alg_wr   (alg_wr),
    .alg_ch   (alg_ch),
    .alg_din  (alg_din),
    .op_result(op_result),
    .cur_ch   (cur_ch),
    .cur_op   (cur_op),
    .s1_enters(s1_enters),
    .s2_enters(s2_enters),
    .s3_enters(s3_enters),
    .s4_enters(s4_enters),
    .alg_I    (alg_I),
    .mod_x    (mod_x),
    .mod_y    (mod_y),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic void checkVal(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void modelReset();
    mSlot = 0;
    mPrev = 0;
    mPrevValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mAlg[i] = 0;
      mS1a[i] = 0;
      mS1b[i] = 0;
      mS2[i]  = 0;
      mS3[i]  = 0;
    end
  endfunction

  // One rising edge of the frame model using the inputs present at that edge
  function automatic void modelEdge();
    int ch;
    if (rst) begin
      modelReset();
      return;
    end
    if (!cen) return;
    if (alg_wr && alg_ch < 3'd6) mAlg[alg_ch] = int'(alg_din);
    if (mPrevValid) begin
      ch = mPrev % 6;
      case (mPrev / 6)
        0: begin
          mS1b[ch] = mS1a[ch];
          mS1a[ch] = int'(op_result);
        end
        1: mS3[ch] = int'(op_result);
        2: mS2[ch] = int'(op_result);
        default: ;
      endcase
    end
    mPrev = mSlot;
    mPrevValid = 1'b1;
    mSlot = (mSlot + 1) % 24;
  endfunction

  // FM connection table; opName 1..4 = S1..S4.
  // Source codes: 0 none, 1 newest S1, 2 S2, 3 S3, 4 older S1 sample
  function automatic void connTable(input int alg, input int opName, output int xs, output int ys);
    xs = 0;
    ys = 0;
    if (opName == 1) begin
      xs = 4;
      ys = 1;
    end else begin
      case (alg)
        0: case (opName) 2: ys = 1; 3: xs = 2; 4: ys = 3; default: ; endcase
        1: case (opName) 3: begin xs = 2; ys = 1; end 4: ys = 3; default: ; endcase
        2: case (opName) 3: xs = 2; 4: begin xs = 3; ys = 1; end default: ; endcase
        3: case (opName) 2: ys = 1; 4: begin xs = 2; ys = 3; end default: ; endcase
        4: case (opName) 2: ys = 1; 4: ys = 3; default: ; endcase
        5: case (opName) 2: ys = 1; 3: xs = 1; 4: ys = 1; default: ; endcase
        6: case (opName) 2: ys = 1; default: ; endcase
        default: ;
      endcase
    end
  endfunction

  function automatic int srcVal(input int code, input int ch);
    case (code)
      1: return mS1a[ch];
      2: return mS2[ch];
      3: return mS3[ch];
      4: return mS1b[ch];
      default: return 0;
    endcase
  endfunction

  function automatic exp_t modelOut();
    exp_t e;
    int grp, ch, opName, xs, ys;
    grp = mSlot / 6;
    ch  = mSlot % 6;
    case (grp)
      0: opName = 1;
      1: opName = 3;
      2: opName = 2;
      default: opName = 4;
    endcase
    connTable(mAlg[ch], opName, xs, ys);
    e.ch     = ch;
    e.op     = grp;
    e.enters = 1 << (opName - 1);
    e.alg    = mAlg[ch];
    e.mx     = srcVal(xs, ch);
    e.my     = srcVal(ys, ch);
    e.zero   = (mSlot == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    checkVal("cur_ch", int'(cur_ch), e.ch);
    checkVal("cur_op", int'(cur_op), e.op);
    checkVal("enters", int'({s4_enters, s3_enters, s2_enters, s1_enters}), e.enters);
    checkVal("alg_I", int'(alg_I), e.alg);
    checkVal("mod_x", int'(mod_x), e.mx);
    checkVal("mod_y", int'(mod_y), e.my);
    checkVal("zero", int'(zero), e.zero);
  endtask

  // One clock cycle: advance the model, drive new inputs, queue the expectation
  task automatic applyStimulus(input bit rstV, input bit cenV, input bit wrV,
                               input logic [2:0] chV, input logic [2:0] dinV);
    int prevSlot;
    @(posedge clk);
    #1;
    modelEdge();
    rst     = rstV;
    cen     = cenV;
    alg_wr  = wrV;
    alg_ch  = chV;
    alg_din = dinV;
    if (rstV) modelReset();
    prevSlot  = (mSlot + 23) % 24;
    op_result = feedEn[prevSlot] ? 14'(feedVal[prevSlot]) : 14'($urandom);
    sbq.push_back(modelOut());
  endtask

  task automatic runTo(input int target);
    int n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
      n++;
    end while (mSlot != target && n < 60);
    if (mSlot != target) checkVal("runTo bound", mSlot, target);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation each cycle
  initial begin
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) checkOutput(sbq.pop_front());
      else if (!stimDone) checkVal("scoreboard empty", 0, 1);
    end
  end

  initial begin
    rst = 1'b1; cen = 1'b0; alg_wr = 1'b0; alg_ch = 3'd0; alg_din = 3'd0; op_result = '0;
    for (int i = 0; i < 24; i++) begin feedEn[i] = 1'b0; feedVal[i] = 0; end
    modelReset();

    // Held in reset with cen toggling
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, i[0], 1'b0, 3'd0, 3'd0);

    // Two full frames with cen held high
    for (int i = 0; i < 49; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);

    // Algorithm 7 into ch3, then a write to nonexistent ch6
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 3'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, 3'd2);
    runTo(3);  settle(); checkVal("alg_I S1/ch3", int'(alg_I), 7);
    runTo(21); settle(); checkVal("alg_I S4/ch3", int'(alg_I), 7);

    // Algorithm 0 on ch0: S1 -> S2 -> S3 chain
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 3'd0);
    feedEn[0] = 1'b1; feedVal[0] = 100;
    feedEn[12] = 1'b1; feedVal[12] = 200;
    runTo(1);
    runTo(12); settle();
    checkVal("S2/ch0 mod_y", int'(mod_y), 100);
    checkVal("S2/ch0 mod_x", int'(mod_x), 0);
    runTo(6); settle();
    checkVal("S3/ch0 mod_x", int'(mod_x), 200);
    feedEn[0] = 1'b0; feedEn[12] = 1'b0;

    // S1/ch1 self-feedback across two frames
    feedEn[1] = 1'b1; feedVal[1] = 5;
    runTo(2);
    runTo(3);
    feedVal[1] = 9;
    runTo(3);
    feedEn[1] = 1'b0;
    runTo(1); settle();
    checkVal("S1/ch1 mod_x", int'(mod_x), 5);
    checkVal("S1/ch1 mod_y", int'(mod_y), 9);

    // Algorithm 2 on ch4, then algorithm 7
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 3'd2);
    feedEn[4] = 1'b1; feedVal[4] = -3;
    feedEn[10] = 1'b1; feedVal[10] = 40;
    runTo(0);
    runTo(22); settle();
    checkVal("S4/ch4 mod_x", int'(mod_x), 40);
    checkVal("S4/ch4 mod_y", int'(mod_y), -3);
    feedEn[4] = 1'b0; feedEn[10] = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd4, 3'd7);
    runTo(10); settle(); checkVal("alg7 S3/ch4 mod_x", int'(mod_x), 0);
    runTo(16); settle(); checkVal("alg7 S2/ch4 mod_y", int'(mod_y), 0);
    runTo(22); settle(); checkVal("alg7 S4/ch4 mod_x", int'(mod_x), 0);
    checkVal("alg7 S4/ch4 mod_y", int'(mod_y), 0);

    // Random traffic: sporadic cen, writes to any channel including 6 and 7
    for (int i = 0; i < 1200; i++)
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Mid-frame reset at slot 13 with cen toggling
    runTo(13);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    settle();
    checkVal("async rst cur_op", int'(cur_op), 0);
    checkVal("async rst zero", int'(zero), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 3'd0);
    settle();
    checkVal("post-rst cur_ch", int'(cur_ch), 1);
    checkVal("post-rst mod_y", int'(mod_y), 0);

    for (int i = 0; i < 600; i++)
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    @(negedge clk);
    #1;
    stimDone = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jt12_opseq.md
JT12_OPSEQ -- requirements
Module: jt12_opseq

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 cen  input  1  clock enable; state advances only on clk edges with cen=1.
REQ-004 alg_wr  input  1  algorithm write strobe, sampled on cen edges.
REQ-005 alg_ch  input  3  channel to write; values 6 and 7 are ignored.
REQ-006 alg_din  input  3  algorithm value 0..7.
REQ-007 op_result  input  14  signed output of the operator that ran in the previous slot.
REQ-008 cur_ch  output  3  channel of the current slot, 0..5.
REQ-009 cur_op  output  2  operator of the current slot: 0=S1, 1=S3, 2=S2, 3=S4.
REQ-010 s1_enters, s2_enters, s3_enters, s4_enters  output  1 each  one-hot operator flags for the current slot.
REQ-011 alg_I  output  3  algorithm of cur_ch.
REQ-012 mod_x, mod_y  output  14 each  signed modulation operands for the current slot.
REQ-013 zero  output  1  high while the slot counter equals 0.

Function
REQ-014 The block SHALL hold a 5-bit slot counter that counts 0..23 and advances by one on each cen edge, wrapping from 23 to 0.
- cur_op = slot/6.
- cur_ch = slot mod 6.
- Slot order is S1 ch0..5, then S3 ch0..5, then S2 ch0..5, then S4 ch0..5.
REQ-015 The s*_enters flags SHALL decode combinationally from cur_op, with exactly one flag high at any time.
REQ-016 The block SHALL hold six 3-bit algorithm registers.
- On a cen edge with alg_wr=1 and alg_ch<6, register alg_ch loads alg_din.
- The new value is visible on alg_I from the next cycle onward.
REQ-017 alg_I SHALL be a combinational read of the algorithm register indexed by cur_ch.
REQ-018 The block SHALL keep a per-channel operator history: s1_d1, s1_d2, s2_out and s3_out, each 14 bits signed.
REQ-019 A registered copy of {cur_ch, cur_op} SHALL delay the slot ID by one cen edge. On each cen edge, op_result is written into the history of that delayed slot:
- S1: s1_d2 <= s1_d1, and s1_d1 <= op_result.
- S2: s2_out <= op_result.
- S3: s3_out <= op_result.
- S4: no write.
REQ-020 The modulation operand sources SHALL be:
- prevprev1: s1_d2 when s1_enters=1, otherwise s1_d1.
- prev1: s1_d1.
- prev2: s2_out.
- internal: s3_out.
REQ-021 mod_x SHALL equal the single source selected by xuse_prevprev1, xuse_prev2 or xuse_internal, and 0 when none is selected.
REQ-022 mod_y SHALL equal the single source selected by yuse_prev1 or yuse_internal, and 0 when none is selected.
REQ-023 mod_x and mod_y SHALL be combinational from the current slot, the algorithm and the history, with zero latency relative to cur_ch/cur_op.
REQ-024 A history write and a read of the same channel register in the same cycle SHALL return the pre-write value; new data is visible from the next cycle.
REQ-025 With cen=0, all registers SHALL hold, and alg_wr SHALL be ignored.

Reset
REQ-026 Asserting rst SHALL immediately force:
- slot counter = 0, so cur_ch=0, cur_op=0, s1_enters=1 and zero=1;
- all algorithm registers = 0;
- all history registers = 0, so mod_x=mod_y=0;
- the delayed slot ID = S4/ch5, so the first post-reset cen edge writes nothing.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release, sequencing restarts at slot 0 on the first cen edge.

Structure
REQ-028 Slot-order constants (S1=0, S3=1, S2=2, S4=3) and the slot count of 24 SHALL live in a shared jt12 package.
REQ-029 The x/y source-select decode SHALL be one instantiated sub-module, jt12_mod, with num_ch=6, driven by the s*_enters flags and alg_I.
REQ-030 The history SHALL be implemented as flip-flops; total RTL SHALL stay within 120-400 lines.

Verification
REQ-031 Release reset with cen=1 for 48 cycles -> slot sequence 0..23 repeats twice, zero pulses at cycles 0 and 24, and s*_enters stay one-hot throughout.
REQ-032 Write alg 7 to ch3, then 2 to ch6 -> alg_I=7 at S*/ch3 slots, and no channel changes for the ch6 write.
REQ-033 Alg 0; feed op_result=100 after S1/ch0 and 200 after S2/ch0 -> S2/ch0 has mod_y=100 and mod_x=0; S3/ch0 of the next frame has mod_x=200.
REQ-034 Feed S1/ch1 results 5, then 9 on consecutive frames -> at S1/ch1, mod_x=5 (prevprev1) and mod_y=9 (prev1).
REQ-035 Alg 2 on ch4 with S1 result -3 and S3 result 40 -> S4/ch4 has mod_x=40 and mod_y=-3; alg 7 on ch4 -> mod_x=mod_y=0 at all slots.
REQ-036 Assert rst at slot 13 with cen toggling -> outputs go to reset values asynchronously, and the first post-release cen edge moves to slot 1 with no history write.
